vga_sync_rx: RTL
================

Name: vga_sync_rx

Overview:
- Sink-side VGA sync decoder; the other end of the team's 640x480 sync generator.
- Samples active-low hsync_n/vsync_n in the pixel clock domain and measures horizontal and vertical timing against parameters.
- Locks after consecutive good frames, then recovers pixel coordinates and an active-video flag for a downstream capture or overlay block.

Parameters:
H_SYNC 96 hsync low width, clocks
H_BACK 48 back porch, clocks
H_ACTIVE 640 active pixels per line
H_TOTAL 800 clocks per line
V_SYNC 2 vsync low width, lines
V_BACK 32 back porch, lines
V_ACTIVE 480 active lines
V_TOTAL 525 lines per frame
LOCK_FRAMES 2 consecutive clean frames required to lock

Ports:
clk in 1 pixel clock
reset in 1 synchronous reset, active-high
hsync_n in 1 horizontal sync, active low, synchronous to clk
vsync_n in 1 vertical sync, active low, synchronous to clk
rx_x out 10 recovered column, 0..H_ACTIVE-1
rx_y out 10 recovered row, 0..V_ACTIVE-1
rx_active out 1 locked and inside active window
locked out 1 lock FSM in LOCKED
line_start out 1 one-clock pulse on hsync fall while locked
frame_start out 1 one-clock pulse on vsync fall while locked
sync_err out 1 one-clock pulse on any timing violation

Behaviour:
- Reset:
  - Outputs all 0.
  - hs_r, hs_r2, vs_r, vs_r2 = 1.
  - hcnt = vcnt = 0; h_seen = v_seen = frame_bad = 0; good_cnt = 0; state SEARCH.
- Input stage:
  - hs_r<=hsync_n; hs_r2<=hs_r.
  - hs_fall = hs_r2 & ~hs_r; hs_rise = ~hs_r2 & hs_r. vsync identical.
- hcnt (10 bit):
  - hs_fall -> 0, else +1.
  - Saturates at 1023.
- vcnt (10 bit):
  - vs_fall alone -> 0.
  - vs_fall with hs_fall in the same cycle -> 1.
  - hs_fall alone -> +1, saturating at 1023.
- Line/frame numbering:
  - hsync falling at input in cycle c gives hcnt=0 in cycle c+2.
  - First sync line has vcnt=1.
- Checks (each sets sync_err next cycle and sets frame_bad):
  - E1: hs_fall & h_seen & hcnt!=H_TOTAL-1.
  - E2: hs_rise & hcnt!=H_SYNC-1.
  - E3: vs_fall & v_seen & vcnt!=V_TOTAL.
  - E4: vs_rise & vcnt!=V_SYNC.
  - E5: hcnt transitions 1022->1023, i.e. hsync lost. Also clears h_seen and v_seen.
  - Simultaneous errors produce a single pulse.
- Seen flags: h_seen set on first hs_fall; v_seen set on first vs_fall.
- Window decode (registered, one clock after counters):
  - h_in = H_SYNC+H_BACK <= hcnt < H_SYNC+H_BACK+H_ACTIVE, i.e. 144..783.
  - v_in = V_SYNC+V_BACK+1 <= vcnt <= V_SYNC+V_BACK+V_ACTIVE, i.e. 35..514.
  - rx_active = locked & h_in & v_in.
  - rx_x = hcnt-144 when h_in, else 0.
  - rx_y = vcnt-35 when v_in, else 0.
  - First active pixel: rx_active=1, rx_x=0 in cycle c+147 relative to the input hsync fall in cycle c.
- Lock FSM, evaluated on vs_fall; frame is good = ~frame_bad & no E3 this cycle. frame_bad clears on every vs_fall after evaluation.
  - SEARCH: vs_fall -> VERIFY, good_cnt=0. Errors are still reported here but do not change state.
  - VERIFY:
    - Good frame -> good_cnt+1.
    - When good_cnt+1==LOCK_FRAMES -> LOCKED.
    - Any error (any cycle) -> SEARCH.
  - LOCKED:
    - Any error -> SEARCH.
    - locked, rx_active, line_start, frame_start drop in the same cycle sync_err asserts.
- locked = (state==LOCKED), registered.
- Reset mid-frame: next cycle returns to reset values. The first hs_fall after reset is not period-checked.

Test Plan:
- Ideal 800x525 timing matching the generator for 4 frames:
  - sync_err never asserts.
  - locked rises on the 3rd vsync fall.
  - Afterwards exactly 640x480 rx_active cycles per frame, with rx_x 0..639 and rx_y 0..479.
- Latency check: first active pixel of line 35 after lock has rx_x=0, rx_y=0, rx_active=1 exactly 147 clocks after the input hsync fall.
- While locked, shorten one line to 799 clocks:
  - sync_err pulses once, on that hs_fall.
  - locked and rx_active drop in that cycle.
  - Relock after 2 clean frames following the next vsync.
- hsync low width 95 clocks (total still 800): E2 pulse at hs_rise; lock lost.
- Hold hsync_n high:
  - Single sync_err when hcnt hits 1023.
  - hcnt stays 1023; no further pulses.
  - Restoring sync relocks.
- Assert reset for 1 clock mid-active-line: all outputs 0 next cycle; state SEARCH; first hs_fall after reset does not raise sync_err.

Source files
------------

// File: rtl/vga_sync_rx_if.sv
// rtl/vga_sync_rx_if.sv - VGA sync receiver signal bundle
// Ports (signals carried by the bundle):
//   hsync_n, vsync_n  : active-low sync inputs from the sync source
//   rx_x, rx_y        : recovered column / row inside the active window
//   rx_active         : locked and inside the active window
//   locked            : lock state machine is in LOCKED
//   line_start        : one-clock pulse on hsync fall while locked
//   frame_start       : one-clock pulse on vsync fall while locked
//   sync_err          : one-clock pulse on any timing violation
// master drives the syncs and observes results; slave is the receiver.
interface vga_sync_rx_if;
  logic       hsync_n;
  logic       vsync_n;
  logic [9:0] rx_x;
  logic [9:0] rx_y;
  logic       rx_active;
  logic       locked;
  logic       line_start;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output hsync_n, vsync_n,
    input  rx_x, rx_y, rx_active, locked, line_start, frame_start, sync_err
  );

  modport slave (
    input  hsync_n, vsync_n,
    output rx_x, rx_y, rx_active, locked, line_start, frame_start, sync_err
  );
endinterface

// File: rtl/vga_sync_rx.sv
// rtl/vga_sync_rx.sv - VGA sync decoder: timing check, lock, pixel coordinate recovery
// Ports:
//   clk   : pixel clock
//   reset : synchronous reset, active-high
//   bus   : vga_sync_rx_if.slave (hsync_n/vsync_n in; rx_x, rx_y, rx_active,
//           locked, line_start, frame_start, sync_err out, all registered)
module vga_sync_rx #(
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int H_ACTIVE    = 640,
  parameter int H_TOTAL     = 800,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 32,
  parameter int V_ACTIVE    = 480,
  parameter int V_TOTAL     = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic         clk,
  input  logic         reset,
  vga_sync_rx_if.slave bus
);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_SYNC_M1 = 10'(H_SYNC - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL);
  localparam logic [9:0] V_SYNC_L  = 10'(V_SYNC);
  localparam logic [9:0] H_START   = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END     = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START   = 10'(V_SYNC + V_BACK + 1);
  localparam logic [9:0] V_END     = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [3:0] LOCK_M1   = 4'(LOCK_FRAMES - 1);
  localparam logic [9:0] CNT_MAX   = 10'h3ff;

  logic       hs_r, hs_r2, vs_r, vs_r2;
  logic [9:0] hcnt, vcnt;
  logic       h_seen, v_seen, frame_bad;
  logic [3:0] good_cnt;
  state_t     state;

  logic [9:0] rx_x_q, rx_y_q;
  logic       rx_active_q, locked_q, line_start_q, frame_start_q, sync_err_q;

  logic hs_fall, hs_rise, vs_fall, vs_rise;
  logic e1, e2, e3, e4, e5, err;
  logic frame_good, lock_next, h_in, v_in;

  assign hs_fall = hs_r2 & ~hs_r;
  assign hs_rise = ~hs_r2 & hs_r;
  assign vs_fall = vs_r2 & ~vs_r;
  assign vs_rise = ~vs_r2 & vs_r;

  // Period checks use the counter value before this cycle's update.
  assign e1  = hs_fall & h_seen & (hcnt != H_LAST);
  assign e2  = hs_rise & (hcnt != H_SYNC_M1);
  assign e3  = vs_fall & v_seen & (vcnt != V_LAST);
  assign e4  = vs_rise & (vcnt != V_SYNC_L);
  // hcnt is about to reach saturation: hsync has gone missing.
  assign e5  = ~hs_fall & (hcnt == 10'd1022);
  assign err = e1 | e2 | e3 | e4 | e5;

  assign frame_good = ~frame_bad & ~e3;

  // Lock status the FSM will hold after this edge; gating the registered
  // outputs with it makes them drop in the same cycle sync_err asserts.
  assign lock_next = ~err & ((state == LOCKED) |
                     ((state == VERIFY) & vs_fall & frame_good & (good_cnt == LOCK_M1)));

  assign h_in = (hcnt >= H_START) && (hcnt < H_END);
  assign v_in = (vcnt >= V_START) && (vcnt <= V_END);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs_r      <= 1'b1;
      hs_r2     <= 1'b1;
      vs_r      <= 1'b1;
      vs_r2     <= 1'b1;
      hcnt      <= '0;
      vcnt      <= '0;
      h_seen    <= 1'b0;
      v_seen    <= 1'b0;
      frame_bad <= 1'b0;
    end else begin
      hs_r  <= bus.hsync_n;
      hs_r2 <= hs_r;
      vs_r  <= bus.vsync_n;
      vs_r2 <= vs_r;

      if (hs_fall)
        hcnt <= '0;
      else if (hcnt != CNT_MAX)
        hcnt <= hcnt + 10'd1;

      // vsync normally falls together with hsync, so the first sync line is 1.
      if (vs_fall)
        vcnt <= hs_fall ? 10'd1 : 10'd0;
      else if (hs_fall && vcnt != CNT_MAX)
        vcnt <= vcnt + 10'd1;

      if (e5)
        h_seen <= 1'b0;
      else if (hs_fall)
        h_seen <= 1'b1;

      if (e5)
        v_seen <= 1'b0;
      else if (vs_fall)
        v_seen <= 1'b1;

      frame_bad <= vs_fall ? 1'b0 : (frame_bad | err);
    end
  end

  // Lock state machine.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
      locked_q <= 1'b0;
    end else begin
      locked_q <= lock_next;
      case (state)
        SEARCH: begin
          if (vs_fall) begin
            state    <= VERIFY;
            good_cnt <= '0;
          end
        end
        VERIFY: begin
          if (err) begin
            state <= SEARCH;
          end else if (vs_fall && frame_good) begin
            good_cnt <= good_cnt + 4'd1;
            if (good_cnt == LOCK_M1)
              state <= LOCKED;
          end
        end
        LOCKED: begin
          if (err)
            state <= SEARCH;
        end
        default: state <= SEARCH;
      endcase
    end
  end

  // Registered outputs, one clock behind the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_x_q        <= '0;
      rx_y_q        <= '0;
      rx_active_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      rx_x_q        <= h_in ? (hcnt - H_START) : 10'd0;
      rx_y_q        <= v_in ? (vcnt - V_START) : 10'd0;
      rx_active_q   <= lock_next & h_in & v_in;
      line_start_q  <= hs_fall & lock_next;
      frame_start_q <= vs_fall & lock_next;
      sync_err_q    <= err;
    end
  end

  assign bus.rx_x        = rx_x_q;
  assign bus.rx_y        = rx_y_q;
  assign bus.rx_active   = rx_active_q;
  assign bus.locked      = locked_q;
  assign bus.line_start  = line_start_q;
  assign bus.frame_start = frame_start_q;
  assign bus.sync_err    = sync_err_q;

endmodule
